rf_writeback_ctrl: RTL and testbench

//  Write-side controller for the 32x32 register file: owns the single write port (addr3/wd3/we3).

---
 rtl/rf_wb_pkg.sv | 19 +
 rtl/rf_wb_fifo.sv | 63 ++++++
 rtl/rf_writeback_ctrl.sv | 110 +++++++++++
 tb/tb_rf_writeback_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rf_wb_pkg: shared widths, write-request record and x0 constant for the     |
// | register-file writeback controller.                       Rev 1.0           |
// +----------------------------------------------------------------------------+
package rf_wb_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  localparam logic [RF_AW-1:0] REG_X0 = '0;

  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [RF_DW-1:0] data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rf_wb_fifo: synchronous FIFO of writeback requests, no fall-through.      |
// |                                                            Rev 1.0         |
// +----------------------------------------------------------------------------+
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  wb_req_t                  i_din,
  input  logic                     i_pop,
  output wb_req_t                  o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_DEPTH = PW'(0) + (PW+1)'(DEPTH);

  wb_req_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == C_DEPTH);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_writeback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rf_writeback_ctrl: owns the register-file write port, merging ALU results |
// | with FIFO-buffered load returns and tracking pending loads.               |
// | Optional decode bypass: define RF_WB_BYPASS_EN.            Rev 1.0         |
// +----------------------------------------------------------------------------+
module rf_writeback_ctrl
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_alu_valid,
  input  logic [AW-1:0]           i_alu_rd,
  input  logic [DW-1:0]           i_alu_data,
  input  logic                    i_ld_valid,
  output logic                    o_ld_ready,
  input  logic [AW-1:0]           i_ld_rd,
  input  logic [DW-1:0]           i_ld_data,
  input  logic                    i_ld_issue,
  input  logic [AW-1:0]           i_ld_issue_rd,
  output logic [AW-1:0]           o_addr3,
  output logic [DW-1:0]           o_wd3,
  output logic                    o_we3,
  output logic [31:0]             o_pending,
  output logic [$clog2(DEPTH):0]  o_fifo_cnt
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [AW-1:0]           i_raddr1,
  input  logic [AW-1:0]           i_raddr2,
  output logic                    o_fwd1_v,
  output logic                    o_fwd2_v,
  output logic [DW-1:0]           o_fwd_data
`endif
);

  wb_req_t  w_push_req;
  wb_req_t  w_head;
  logic     w_fifo_full;
  logic     w_fifo_empty;
  logic     w_alu_sel;
  logic     w_pop;
  logic     w_push;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;

  // ALU has no backpressure, so it always owns the port unless it targets x0.
  assign w_alu_sel  = i_alu_valid && (i_alu_rd != REG_X0);
  assign w_pop      = !w_alu_sel && !w_fifo_empty;
  assign o_ld_ready = !w_fifo_full;
  assign w_push     = i_ld_valid && o_ld_ready && (i_ld_rd != REG_X0);

  assign w_push_req.rd   = i_ld_rd;
  assign w_push_req.data = i_ld_data;

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_din   (w_push_req),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (o_fifo_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_we3   <= 1'b0;
      o_addr3 <= '0;
      o_wd3   <= '0;
    end else if (w_alu_sel) begin
      o_we3   <= 1'b1;
      o_addr3 <= i_alu_rd;
      o_wd3   <= i_alu_data;
    end else if (w_pop) begin
      o_we3   <= 1'b1;
      o_addr3 <= w_head.rd;
      o_wd3   <= w_head.data;
    end else begin
      o_we3   <= 1'b0;
    end
  end

  // Clear lands on the same edge that raises o_we3 for the load; a new issue wins.
  assign w_set_mask = (i_ld_issue && (i_ld_issue_rd != REG_X0)) ? (32'd1 << i_ld_issue_rd) : 32'd0;
  assign w_clr_mask = w_pop ? (32'd1 << w_head.rd) : 32'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pending <= '0;
    end else begin
      o_pending <= (o_pending & ~w_clr_mask) | w_set_mask;
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign o_fwd1_v   = o_we3 && (o_addr3 == i_raddr1) && (i_raddr1 != REG_X0);
  assign o_fwd2_v   = o_we3 && (o_addr3 == i_raddr2) && (i_raddr2 != REG_X0);
  assign o_fwd_data = o_wd3;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rf_writeback_ctrl: directed self-checking bench for rf_writeback_ctrl. |
// |                                                            Rev 1.0         |
// +----------------------------------------------------------------------------+
module tb_rf_writeback_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_ld_valid;
  logic        o_ld_ready;
  logic [4:0]  i_ld_rd;
  logic [31:0] i_ld_data;
  logic        i_ld_issue;
  logic [4:0]  i_ld_issue_rd;
  logic [4:0]  o_addr3;
  logic [31:0] o_wd3;
  logic        o_we3;
  logic [31:0] o_pending;
  logic [2:0]  o_fifo_cnt;
`ifdef RF_WB_BYPASS_EN
  logic [4:0]  i_raddr1;
  logic [4:0]  i_raddr2;
  logic        o_fwd1_v;
  logic        o_fwd2_v;
  logic [31:0] o_fwd_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  rf_writeback_ctrl #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_alu_valid   (i_alu_valid),
    .i_alu_rd      (i_alu_rd),
    .i_alu_data    (i_alu_data),
    .i_ld_valid    (i_ld_valid),
    .o_ld_ready    (o_ld_ready),
    .i_ld_rd       (i_ld_rd),
    .i_ld_data     (i_ld_data),
    .i_ld_issue    (i_ld_issue),
    .i_ld_issue_rd (i_ld_issue_rd),
    .o_addr3       (o_addr3),
    .o_wd3         (o_wd3),
    .o_we3         (o_we3),
    .o_pending     (o_pending),
    .o_fifo_cnt    (o_fifo_cnt)
`ifdef RF_WB_BYPASS_EN
    ,
    .i_raddr1      (i_raddr1),
    .i_raddr2      (i_raddr2),
    .o_fwd1_v      (o_fwd1_v),
    .o_fwd2_v      (o_fwd2_v),
    .o_fwd_data    (o_fwd_data)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_alu_valid   = 1'b0;
    i_alu_rd      = '0;
    i_alu_data    = '0;
    i_ld_valid    = 1'b0;
    i_ld_rd       = '0;
    i_ld_data     = '0;
    i_ld_issue    = 1'b0;
    i_ld_issue_rd = '0;
`ifdef RF_WB_BYPASS_EN
    i_raddr1      = '0;
    i_raddr2      = '0;
`endif
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    idle_inputs();
    #12;
    n_cmp++; if (o_we3 !== 1'b0) begin n_err++; $display("FAIL reset_we3: got %b want 0", o_we3); end
    n_cmp++; if (o_addr3 !== 5'd0) begin n_err++; $display("FAIL reset_addr3: got %0d want 0", o_addr3); end
    n_cmp++; if (o_wd3 !== 32'd0) begin n_err++; $display("FAIL reset_wd3: got %h want 0", o_wd3); end
    n_cmp++; if (o_pending !== 32'd0) begin n_err++; $display("FAIL reset_pending: got %h want 0", o_pending); end
    n_cmp++; if (o_fifo_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", o_fifo_cnt); end
    n_cmp++; if (o_ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", o_ld_ready); end
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu_only();
    i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF;
    step();
    i_alu_valid = 1'b0;
    n_cmp++; if (o_we3 !== 1'b1) begin n_err++; $display("FAIL alu_we3: got %b want 1", o_we3); end
    n_cmp++; if (o_addr3 !== 5'd5) begin n_err++; $display("FAIL alu_addr3: got %0d want 5", o_addr3); end
    n_cmp++; if (o_wd3 !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_wd3: got %h want deadbeef", o_wd3); end
    step();
    n_cmp++; if (o_we3 !== 1'b0) begin n_err++; $display("FAIL alu_idle_we3: got %b want 0", o_we3); end
    n_cmp++; if (o_addr3 !== 5'd5 || o_wd3 !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL alu_idle_hold: got %0d/%h want 5/deadbeef", o_addr3, o_wd3);
    end
  endtask

  task automatic test_contention();
    i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'h33;
    i_ld_valid  = 1'b1; i_ld_rd  = 5'd7; i_ld_data  = 32'h77;
    step();
    idle_inputs();
    n_cmp++; if (o_we3 !== 1'b1 || o_addr3 !== 5'd3 || o_wd3 !== 32'h33) begin
      n_err++; $display("FAIL cont_alu_first: got we=%b a=%0d d=%h want 1/3/33", o_we3, o_addr3, o_wd3);
    end
    n_cmp++; if (o_fifo_cnt !== 3'd1) begin n_err++; $display("FAIL cont_cnt1: got %0d want 1", o_fifo_cnt); end
    step();
    n_cmp++; if (o_we3 !== 1'b1 || o_addr3 !== 5'd7 || o_wd3 !== 32'h77) begin
      n_err++; $display("FAIL cont_load_next: got we=%b a=%0d d=%h want 1/7/77", o_we3, o_addr3, o_wd3);
    end
    n_cmp++; if (o_fifo_cnt !== 3'd0) begin n_err++; $display("FAIL cont_cnt0: got %0d want 0", o_fifo_cnt); end
    step();
    n_cmp++; if (o_we3 !== 1'b0) begin n_err++; $display("FAIL cont_idle: got %b want 0", o_we3); end
  endtask

  task automatic test_full();
    int idx;
    logic acc;
    logic exp_rdy;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      i_alu_valid = (c < 6);
      i_alu_rd    = 5'd1;
      i_alu_data  = 32'(c);
      i_ld_valid  = (idx < 5);
      i_ld_rd     = 5'(10 + idx);
      i_ld_data   = 32'h100 + 32'(idx);
      exp_rdy = !(c >= 4 && c <= 6);
      n_cmp++; if (o_ld_ready !== exp_rdy) begin
        n_err++; $display("FAIL full_ready c=%0d: got %b want %b", c, o_ld_ready, exp_rdy);
      end
      acc = i_ld_valid && o_ld_ready;
      step();
      if (acc) idx++;
      if (c <= 10) begin
        exp_a = (c < 6) ? 5'd1 : 5'(10 + c - 6);
        exp_d = (c < 6) ? 32'(c) : 32'h100 + 32'(c - 6);
        n_cmp++; if (o_we3 !== 1'b1 || o_addr3 !== exp_a || o_wd3 !== exp_d) begin
          n_err++; $display("FAIL full_write c=%0d: got we=%b a=%0d d=%h want 1/%0d/%h", c, o_we3, o_addr3, o_wd3, exp_a, exp_d);
        end
      end else begin
        n_cmp++; if (o_we3 !== 1'b0) begin n_err++; $display("FAIL full_drained_we3: got %b want 0", o_we3); end
      end
      if (c == 3) begin
        n_cmp++; if (o_fifo_cnt !== 3'd4) begin n_err++; $display("FAIL full_cnt4: got %0d want 4", o_fifo_cnt); end
      end
    end
    idle_inputs();
    n_cmp++; if (o_fifo_cnt !== 3'd0) begin n_err++; $display("FAIL full_cnt_end: got %0d want 0", o_fifo_cnt); end
  endtask

  task automatic test_scoreboard();
    i_ld_issue = 1'b1; i_ld_issue_rd = 5'd9;
    step();
    i_ld_issue = 1'b0;
    n_cmp++; if (o_pending !== 32'h200) begin n_err++; $display("FAIL sb_set: got %h want 00000200", o_pending); end
    i_ld_valid = 1'b1; i_ld_rd = 5'd9; i_ld_data = 32'h99;
    step();
    i_ld_valid = 1'b0;
    n_cmp++; if (o_pending !== 32'h200 || o_we3 !== 1'b0) begin
      n_err++; $display("FAIL sb_pushed: got p=%h we=%b want 00000200/0", o_pending, o_we3);
    end
    step();
    n_cmp++; if (o_we3 !== 1'b1 || o_addr3 !== 5'd9 || o_wd3 !== 32'h99) begin
      n_err++; $display("FAIL sb_write: got we=%b a=%0d d=%h want 1/9/99", o_we3, o_addr3, o_wd3);
    end
    n_cmp++; if (o_pending !== 32'h0) begin n_err++; $display("FAIL sb_clear: got %h want 0", o_pending); end
    i_ld_issue = 1'b1; i_ld_issue_rd = 5'd9;
    i_ld_valid = 1'b1; i_ld_rd = 5'd9; i_ld_data = 32'h9A;
    step();
    i_ld_valid = 1'b0;
    step();
    i_ld_issue = 1'b0;
    n_cmp++; if (o_we3 !== 1'b1 || o_addr3 !== 5'd9 || o_wd3 !== 32'h9A) begin
      n_err++; $display("FAIL sb_write2: got we=%b a=%0d d=%h want 1/9/9a", o_we3, o_addr3, o_wd3);
    end
    n_cmp++; if (o_pending !== 32'h200) begin n_err++; $display("FAIL sb_set_wins: got %h want 00000200", o_pending); end
    i_ld_issue = 1'b1; i_ld_issue_rd = 5'd0;
    step();
    i_ld_issue = 1'b0;
    n_cmp++; if (o_pending !== 32'h200) begin n_err++; $display("FAIL sb_x0_issue: got %h want 00000200", o_pending); end
  endtask

  task automatic test_x0();
    i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'h55;
    i_ld_valid  = 1'b1; i_ld_rd  = 5'd0; i_ld_data  = 32'h66;
    n_cmp++; if (o_ld_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", o_ld_ready); end
    step();
    idle_inputs();
    n_cmp++; if (o_we3 !== 1'b0) begin n_err++; $display("FAIL x0_we3: got %b want 0", o_we3); end
    n_cmp++; if (o_fifo_cnt !== 3'd0) begin n_err++; $display("FAIL x0_cnt: got %0d want 0", o_fifo_cnt); end
  endtask

`ifdef RF_WB_BYPASS_EN
  task automatic test_bypass();
    i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'h12345678;
    step();
    idle_inputs();
    i_raddr1 = 5'd5; i_raddr2 = 5'd6;
    #1;
    n_cmp++; if (o_fwd1_v !== 1'b1 || o_fwd2_v !== 1'b0 || o_fwd_data !== 32'h12345678) begin
      n_err++; $display("FAIL bypass: got v1=%b v2=%b d=%h want 1/0/12345678", o_fwd1_v, o_fwd2_v, o_fwd_data);
    end
    step();
    n_cmp++; if (o_fwd1_v !== 1'b0) begin n_err++; $display("FAIL bypass_idle: got %b want 0", o_fwd1_v); end
    idle_inputs();
  endtask
`endif

  task automatic test_reset_mid();
    i_alu_valid = 1'b1; i_alu_rd = 5'd2; i_alu_data = 32'hAA;
    i_ld_issue  = 1'b1; i_ld_issue_rd = 5'd4;
    i_ld_valid  = 1'b1; i_ld_rd = 5'd20; i_ld_data = 32'h20;
    step();
    i_ld_issue = 1'b0;
    i_ld_rd = 5'd21; i_ld_data = 32'h21;
    step();
    i_ld_valid = 1'b0;
    n_cmp++; if (o_fifo_cnt !== 3'd2 || o_we3 !== 1'b1 || o_pending !== 32'h210) begin
      n_err++; $display("FAIL mid_pre: got cnt=%0d we=%b p=%h want 2/1/00000210", o_fifo_cnt, o_we3, o_pending);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if (o_we3 !== 1'b0 || o_pending !== 32'h0 || o_fifo_cnt !== 3'd0) begin
      n_err++; $display("FAIL mid_reset: got we=%b p=%h cnt=%0d want 0/0/0", o_we3, o_pending, o_fifo_cnt);
    end
    idle_inputs();
    #3;
    i_rst_n = 1'b1;
    step();
    n_cmp++; if (o_we3 !== 1'b0 || o_fifo_cnt !== 3'd0) begin
      n_err++; $display("FAIL mid_after: got we=%b cnt=%0d want 0/0", o_we3, o_fifo_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_contention();
    test_full();
    test_scoreboard();
    test_x0();
`ifdef RF_WB_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
